// File: rtl/layer1_pkg.sv
// rtl/layer1_pkg.sv - shared constants and FSM encoding for the layer-1 pooling PE
// Purpose: default sample/feature-map sizes, pooled-map width and the row-phase
//          state encoding used by layer1_pool_pe.
// Ports:   none (package).
package layer1_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int FMAP_W_DEF = 24;
  localparam int POOL_W     = FMAP_W_DEF / 2;

  // EVEN_ROW collects horizontal pairs into the line buffer, ODD_ROW merges them
  // with the second row of each window, DONE parks the block until reset.
  typedef enum logic [1:0] {
    EVEN_ROW = 2'd0,
    ODD_ROW  = 2'd1,
    DONE     = 2'd2
  } pool_state_e;

endpackage

// File: rtl/signed_max2.sv
// rtl/signed_max2.sv - combinational signed maximum of two samples
// Purpose: max-pool combine primitive.
// Ports:   a_i, b_i - signed operands; max_o - the larger of the two.
module signed_max2
  import layer1_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [DATA_W-1:0] b_i,
  output logic signed [DATA_W-1:0] max_o
);

  assign max_o = (a_i >= b_i) ? a_i : b_i;

endmodule

// File: rtl/layer1_pool_pe.sv
// rtl/layer1_pool_pe.sv - streaming 2x2 stride-2 pooling of a raster-order feature map
// Purpose: consumes FMAP_W x FMAP_W signed samples and emits (FMAP_W/2)^2 pooled
//          samples in raster order. Signed max by default; define LAYER1_POOL_AVG_EN
//          to switch to a 4-sample average (sum arithmetically shifted right by 2).
// Ports:   clk, reset (async, active-high)
//          conv_out    - input sample strobe, datain - signed input sample
//          pool_out    - single-cycle output strobe, dataout - pooled sample (held)
//          pool_finish - sticky, set with the last pooled sample of the frame
module layer1_pool_pe
  import layer1_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int FMAP_W = FMAP_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     conv_out,
  input  logic signed [DATA_W-1:0] datain,
  output logic                     pool_out,
  output logic signed [DATA_W-1:0] dataout,
  output logic                     pool_finish
);

  localparam int LB_DEPTH = FMAP_W / 2;
  localparam int CNT_W    = (FMAP_W > 2) ? $clog2(FMAP_W) : 1;
  localparam int IDX_W    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
`ifdef LAYER1_POOL_AVG_EN
  // Two guard bits hold a sum of four samples without overflow.
  localparam int ACC_W = DATA_W + 2;
`else
  localparam int ACC_W = DATA_W;
`endif

  pool_state_e              state_q;
  logic [CNT_W-1:0]         col_q;
  logic [CNT_W-1:0]         row_q;
  logic signed [ACC_W-1:0]  pair_q;
  logic                     pool_out_q;
  logic signed [DATA_W-1:0] dataout_q;
  logic                     finish_q;

  // One partial result per window column, written on even rows, read on odd rows.
  logic signed [ACC_W-1:0]  line_buf [LB_DEPTH];

  logic                     accept;
  logic                     last_col;
  logic                     last_row;
  logic [IDX_W-1:0]         lb_idx;
  logic signed [ACC_W-1:0]  lb_rd;
  logic signed [ACC_W-1:0]  din_acc;
  logic signed [ACC_W-1:0]  pair_comb;
  logic signed [ACC_W-1:0]  lb_comb;
  logic signed [DATA_W-1:0] out_val;

  assign accept   = conv_out && (state_q != DONE);
  assign last_col = (col_q == CNT_W'(FMAP_W - 1));
  assign last_row = (row_q == CNT_W'(FMAP_W - 1));
  assign lb_idx   = IDX_W'(col_q >> 1);
  assign lb_rd    = line_buf[lb_idx];

`ifdef LAYER1_POOL_AVG_EN
  assign din_acc   = {{2{datain[DATA_W-1]}}, datain};
  assign pair_comb = pair_q + din_acc;
  assign lb_comb   = lb_rd + din_acc;
  // Dropping the two LSBs of the 4-sample sum is an arithmetic shift right by 2;
  // the result always fits DATA_W because it is the floor of a mean.
  assign out_val   = pair_comb[DATA_W+1:2];
`else
  assign din_acc = datain;

  signed_max2 #(.DATA_W(DATA_W)) u_max_pair (
    .a_i  (pair_q),
    .b_i  (datain),
    .max_o(pair_comb)
  );

  signed_max2 #(.DATA_W(DATA_W)) u_max_line (
    .a_i  (lb_rd),
    .b_i  (datain),
    .max_o(lb_comb)
  );

  assign out_val = pair_comb;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= EVEN_ROW;
      col_q      <= '0;
      row_q      <= '0;
      pair_q     <= '0;
      pool_out_q <= 1'b0;
      dataout_q  <= '0;
      finish_q   <= 1'b0;
    end else begin
      pool_out_q <= 1'b0;
      if (accept) begin
        if (last_col) begin
          col_q <= '0;
          row_q <= last_row ? '0 : row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end

        case (state_q)
          EVEN_ROW: begin
            if (!col_q[0]) begin
              pair_q <= din_acc;
            end
            if (last_col) begin
              state_q <= ODD_ROW;
            end
          end
          ODD_ROW: begin
            if (!col_q[0]) begin
              pair_q <= lb_comb;
            end else begin
              pool_out_q <= 1'b1;
              dataout_q  <= out_val;
            end
            if (last_col) begin
              if (last_row) begin
                state_q  <= DONE;
                finish_q <= 1'b1;
              end else begin
                state_q <= EVEN_ROW;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Contents need no reset: every entry is rewritten on an even row before the
  // odd row that reads it.
  always_ff @(posedge clk) begin
    if (accept && (state_q == EVEN_ROW) && col_q[0]) begin
      line_buf[lb_idx] <= pair_comb;
    end
  end

  assign pool_out    = pool_out_q;
  assign dataout     = dataout_q;
  assign pool_finish = finish_q;

endmodule
